// File: rtl/tank_ctrl.sv
// Per-player tank controller: frame-paced grid movement and facing, plus one bullet in flight.
// All outputs registered and update the cycle after the qualifying frame tick; i_freeze holds all motion.
module tank_ctrl #(
  parameter int MAX_X         = 39,
  parameter int MAX_Y         = 29,
  parameter int INIT_X        = 32,
  parameter int INIT_Y        = 3,
  parameter int INIT_DIR      = 0,
  parameter int MOVE_PERIOD   = 8,
  parameter int BULLET_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame_tick,
  input  logic       i_freeze,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_fire,
  output logic [5:0] o_tank_x,
  output logic [5:0] o_tank_y,
  output logic [1:0] o_tank_dir,
  output logic       o_bullet_valid,
  output logic [5:0] o_bullet_x,
  output logic [5:0] o_bullet_y,
  output logic [1:0] o_bullet_dir
);

  localparam int MCW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int BCW = (BULLET_PERIOD > 1) ? $clog2(BULLET_PERIOD) : 1;
  localparam logic [MCW-1:0] MOVE_LAST = MCW'(MOVE_PERIOD - 1);
  localparam logic [BCW-1:0] BUL_LAST  = BCW'(BULLET_PERIOD - 1);
  localparam logic [5:0]     X_LIM     = 6'(MAX_X);
  localparam logic [5:0]     Y_LIM     = 6'(MAX_Y);

  typedef enum logic {IDLE, FLYING} bstate_t;

  bstate_t        state_q, state_d;
  logic [MCW-1:0] move_cnt_q, move_cnt_d;
  logic [BCW-1:0] bul_cnt_q, bul_cnt_d;
  logic           fire_d;
  logic           fire_rise;
  logic           req_vld;
  logic [1:0]     req_dir;
  logic [5:0]     tank_x_d, tank_y_d;
  logic [1:0]     tank_dir_d;
  logic           bul_vld_d;
  logic [5:0]     bul_x_d, bul_y_d;
  logic [1:0]     bul_dir_d;
  logic [5:0]     step_x, step_y;
  logic           step_out;

  assign fire_rise = i_fire & ~fire_d;

  always_comb begin
    req_vld = i_up | i_down | i_left | i_right;
    req_dir = 2'd1;
    if (i_up)        req_dir = 2'd0;
    else if (i_down) req_dir = 2'd2;
    else if (i_left) req_dir = 2'd3;
  end

  // Edge test happens before the arithmetic so nothing relies on 6-bit wrap.
  always_comb begin
    step_x   = o_bullet_x;
    step_y   = o_bullet_y;
    step_out = 1'b0;
    case (o_bullet_dir)
      2'd0: if (o_bullet_y == 6'd0)   step_out = 1'b1; else step_y = o_bullet_y - 6'd1;
      2'd1: if (o_bullet_x >= X_LIM)  step_out = 1'b1; else step_x = o_bullet_x + 6'd1;
      2'd2: if (o_bullet_y >= Y_LIM)  step_out = 1'b1; else step_y = o_bullet_y + 6'd1;
      default: if (o_bullet_x == 6'd0) step_out = 1'b1; else step_x = o_bullet_x - 6'd1;
    endcase
  end

  always_comb begin
    move_cnt_d = move_cnt_q;
    tank_x_d   = o_tank_x;
    tank_y_d   = o_tank_y;
    tank_dir_d = o_tank_dir;
    if (!i_freeze) begin
      if (!req_vld) begin
        move_cnt_d = MOVE_LAST;
      end else if (i_frame_tick) begin
        if (move_cnt_q == MOVE_LAST) begin
          move_cnt_d = '0;
          if (req_dir != o_tank_dir) begin
            tank_dir_d = req_dir;
          end else begin
            case (req_dir)
              2'd0: if (o_tank_y != 6'd0) tank_y_d = o_tank_y - 6'd1;
              2'd1: if (o_tank_x < X_LIM) tank_x_d = o_tank_x + 6'd1;
              2'd2: if (o_tank_y < Y_LIM) tank_y_d = o_tank_y + 6'd1;
              default: if (o_tank_x != 6'd0) tank_x_d = o_tank_x - 6'd1;
            endcase
          end
        end else begin
          move_cnt_d = move_cnt_q + MCW'(1);
        end
      end
    end
  end

  // Spawn copies the pre-move tank registers, so a same-cycle tank action does not leak in.
  always_comb begin
    state_d   = state_q;
    bul_cnt_d = bul_cnt_q;
    bul_vld_d = o_bullet_valid;
    bul_x_d   = o_bullet_x;
    bul_y_d   = o_bullet_y;
    bul_dir_d = o_bullet_dir;
    case (state_q)
      IDLE: begin
        if (fire_rise && !i_freeze) begin
          state_d   = FLYING;
          bul_vld_d = 1'b1;
          bul_x_d   = o_tank_x;
          bul_y_d   = o_tank_y;
          bul_dir_d = o_tank_dir;
          bul_cnt_d = '0;
        end
      end
      default: begin
        if (i_frame_tick && !i_freeze) begin
          if (bul_cnt_q == BUL_LAST) begin
            bul_cnt_d = '0;
            if (step_out) begin
              state_d   = IDLE;
              bul_vld_d = 1'b0;
            end else begin
              bul_x_d = step_x;
              bul_y_d = step_y;
            end
          end else begin
            bul_cnt_d = bul_cnt_q + BCW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      move_cnt_q     <= MOVE_LAST;
      bul_cnt_q      <= '0;
      fire_d         <= 1'b0;
      o_tank_x       <= 6'(INIT_X);
      o_tank_y       <= 6'(INIT_Y);
      o_tank_dir     <= 2'(INIT_DIR);
      o_bullet_valid <= 1'b0;
      o_bullet_x     <= '0;
      o_bullet_y     <= '0;
      o_bullet_dir   <= '0;
    end else begin
      state_q        <= state_d;
      move_cnt_q     <= move_cnt_d;
      bul_cnt_q      <= bul_cnt_d;
      fire_d         <= i_fire;
      o_tank_x       <= tank_x_d;
      o_tank_y       <= tank_y_d;
      o_tank_dir     <= tank_dir_d;
      o_bullet_valid <= bul_vld_d;
      o_bullet_x     <= bul_x_d;
      o_bullet_y     <= bul_y_d;
      o_bullet_dir   <= bul_dir_d;
    end
  end

endmodule

// File: tb/tb_tank_ctrl.sv
// Bench for tank_ctrl: per-cycle reference model feeds a scoreboard, plus directed spot checks.
module tb_tank_ctrl;
  localparam int MP = 8, BP = 2, MAXX = 39, MAXY = 29;
  localparam bit [4:0] B_NONE = 5'b00000, B_UP = 5'b10000, B_DOWN = 5'b01000,
                       B_LEFT = 5'b00100, B_RIGHT = 5'b00010, B_FIRE = 5'b00001;

  logic clk = 1'b0;
  logic rst, tick, freeze, up, down, left, right, fire;
  logic [5:0] tx, ty, bx, by;
  logic [1:0] td, bd;
  logic       bv;

  always #5 clk = ~clk;

  tank_ctrl #(
    .MAX_X(MAXX), .MAX_Y(MAXY), .INIT_X(32), .INIT_Y(3), .INIT_DIR(0),
    .MOVE_PERIOD(MP), .BULLET_PERIOD(BP)
  ) dut (
    .clk(clk), .rst(rst), .i_frame_tick(tick), .i_freeze(freeze),
    .i_up(up), .i_down(down), .i_left(left), .i_right(right), .i_fire(fire),
    .o_tank_x(tx), .o_tank_y(ty), .o_tank_dir(td),
    .o_bullet_valid(bv), .o_bullet_x(bx), .o_bullet_y(by), .o_bullet_dir(bd)
  );

  typedef struct { int x; int y; int dir; int bv; int bx; int by; int bd; } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_checks = 0, n_errors = 0;
  int spawns = 0;
  logic bv_prev = 1'b0;
  int m_x, m_y, m_dir, m_bv, m_bx, m_by, m_bd, m_mc, m_bc, m_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic model_cycle(input bit r, input bit t, input bit fz, input bit [4:0] b);
    int rq, ox, oy, od, nx, ny;
    if (r) begin
      m_x = 32; m_y = 3; m_dir = 0; m_bv = 0; m_bx = 0; m_by = 0; m_bd = 0;
      m_mc = MP - 1; m_bc = 0; m_fd = 0;
      return;
    end
    ox = m_x; oy = m_y; od = m_dir;
    if (b[4])      rq = 0;
    else if (b[3]) rq = 2;
    else if (b[2]) rq = 3;
    else if (b[1]) rq = 1;
    else           rq = -1;
    if (!fz) begin
      if (m_bv == 0) begin
        if (b[0] && m_fd == 0) begin
          m_bv = 1; m_bx = ox; m_by = oy; m_bd = od; m_bc = 0;
        end
      end else if (t) begin
        if (m_bc == BP - 1) begin
          m_bc = 0;
          nx = m_bx; ny = m_by;
          case (m_bd)
            0: ny = ny - 1;
            1: nx = nx + 1;
            2: ny = ny + 1;
            default: nx = nx - 1;
          endcase
          if (nx < 0 || nx > MAXX || ny < 0 || ny > MAXY) m_bv = 0;
          else begin m_bx = nx; m_by = ny; end
        end else m_bc = m_bc + 1;
      end
      if (rq < 0) m_mc = MP - 1;
      else if (t) begin
        if (m_mc == MP - 1) begin
          m_mc = 0;
          if (rq != m_dir) m_dir = rq;
          else begin
            nx = m_x; ny = m_y;
            case (rq)
              0: ny = ny - 1;
              1: nx = nx + 1;
              2: ny = ny + 1;
              default: nx = nx - 1;
            endcase
            if (nx >= 0 && nx <= MAXX && ny >= 0 && ny <= MAXY) begin m_x = nx; m_y = ny; end
          end
        end else m_mc = m_mc + 1;
      end
    end
    m_fd = b[0];
  endtask

  task automatic drive(input bit r, input bit t, input bit fz, input bit [4:0] b);
    @(negedge clk);
    rst = r; tick = t; freeze = fz;
    {up, down, left, right, fire} = b;
    model_cycle(r, t, fz, b);
    sb.push_back('{m_x, m_y, m_dir, m_bv, m_bx, m_by, m_bd});
  endtask

  task automatic ticks(input int n, input bit [4:0] b, input bit fz);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, fz, b);
      drive(1'b0, 1'b0, fz, b);
    end
  endtask

  task automatic look;
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (bv === 1'b1 && bv_prev === 1'b0) spawns++;
    bv_prev = bv;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("tank_x", tx, e.x);
      check("tank_y", ty, e.y);
      check("tank_dir", td, e.dir);
      check("bullet_valid", bv, e.bv);
      check("bullet_x", bx, e.bx);
      check("bullet_y", by, e.by);
      check("bullet_dir", bd, e.bd);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    bit r, t, fz;
    bit [4:0] b;
    rst = 1'b1; tick = 1'b0; freeze = 1'b0;
    {up, down, left, right, fire} = B_NONE;

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, B_UP);
    look;
    check("rst_x", tx, 32); check("rst_y", ty, 3); check("rst_dir", td, 0); check("rst_bv", bv, 0);

    drive(1'b0, 1'b1, 1'b0, B_UP); look; check("up_first_tick_y", ty, 2);
    drive(1'b0, 1'b0, 1'b0, B_UP);
    ticks(7, B_UP, 1'b0); look; check("up_8_ticks_y", ty, 2);
    ticks(1, B_UP, 1'b0); look; check("up_9th_tick_y", ty, 1);

    drive(1'b0, 1'b0, 1'b0, B_NONE);
    ticks(1, B_RIGHT, 1'b0); look; check("turn_right_dir", td, 1); check("turn_right_x", tx, 32);
    ticks(8, B_RIGHT, 1'b0); look; check("right_step_x", tx, 33);
    ticks(48 + 16, B_RIGHT, 1'b0); look; check("clamp_max_x", tx, 39);

    drive(1'b0, 1'b0, 1'b0, B_NONE);
    ticks(25, B_UP, 1'b0); look; check("clamp_min_y", ty, 0);
    drive(1'b0, 1'b0, 1'b0, B_NONE);
    ticks(1 + 39 * 8 + 16, B_LEFT, 1'b0); look; check("clamp_min_x", tx, 0); check("left_dir", td, 3);

    drive(1'b0, 1'b0, 1'b0, B_NONE);
    ticks(1 + 10 * 8, B_DOWN, 1'b0);
    drive(1'b0, 1'b0, 1'b0, B_NONE);
    ticks(1 + 10 * 8, B_RIGHT, 1'b0);
    drive(1'b0, 1'b0, 1'b0, B_NONE);
    ticks(1, B_LEFT, 1'b0); look;
    check("pos10_x", tx, 10); check("pos10_y", ty, 10); check("pos10_dir", td, 3);

    s0 = spawns;
    drive(1'b0, 1'b0, 1'b0, B_FIRE); look;
    check("spawn_bv", bv, 1); check("spawn_bx", bx, 10); check("spawn_by", by, 10); check("spawn_bd", bd, 3);
    drive(1'b0, 1'b0, 1'b0, B_NONE);
    ticks(2, B_NONE, 1'b0); look; check("bullet_step_x", bx, 9);
    drive(1'b0, 1'b0, 1'b0, B_FIRE);
    drive(1'b0, 1'b0, 1'b0, B_NONE); look;
    check("refire_ignored_x", bx, 9); check("refire_spawns", spawns - s0, 1);
    ticks(3, B_NONE, 1'b0);
    ticks(10, B_LEFT | B_FIRE, 1'b1); look;
    check("freeze_bx", bx, 8); check("freeze_tank_x", tx, 10);
    ticks(1, B_NONE, 1'b0); look; check("resume_bx", bx, 7); check("resume_spawns", spawns - s0, 1);
    ticks(20, B_NONE, 1'b0); look; check("exit_bv", bv, 0); check("exit_bx", bx, 0);

    s0 = spawns;
    ticks(25, B_FIRE, 1'b0); look;
    check("held_fire_spawns", spawns - s0, 1); check("held_fire_bv", bv, 0);

    drive(1'b0, 1'b0, 1'b1, B_NONE);
    drive(1'b0, 1'b0, 1'b1, B_FIRE);
    drive(1'b0, 1'b0, 1'b0, B_FIRE);
    drive(1'b0, 1'b0, 1'b0, B_NONE); look;
    check("freeze_fire_bv", bv, 0);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      t  = ($urandom_range(0, 2) == 0);
      fz = ($urandom_range(0, 9) == 0);
      b  = 5'($urandom);
      drive(r, t, fz, b);
    end

    drive(1'b0, 1'b0, 1'b0, B_NONE);
    @(posedge clk); @(posedge clk); #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
